// File: rtl/pipelined_carry_select_adder_if.sv
// rtl/pipelined_carry_select_adder_if.sv - operand/result handshake bundle for the pipelined carry-select adder
interface pipelined_carry_select_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// rtl/pipelined_carry_select_adder.sv - pipelined carry-select add/sub, S=N/(B*BPS) stages
// Optional saturation on signed overflow when CSEL_SATURATE_EN is defined.
module pipelined_carry_select_adder #(
  parameter int N   = 32,
  parameter int B   = 4,
  parameter int BPS = 2
) (
  input logic                          clk,
  input logic                          rst_n,
  pipelined_carry_select_adder_if.slave bus
);
  localparam int S = N / (B * BPS);

  // One global advance keeps every stage in lockstep; bubbles travel like beats.
  logic advance;
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < S; k++) begin : stg
    logic         v_in;
    logic         c_in;
    logic         c_out;
    logic         c_mid;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [N-1:0] s_in;
    logic [N-1:0] s_out;
    logic [B:0]   p0;
    logic [B:0]   p1;
    logic         unused_in;

    if (k == 0) begin : src
      assign v_in = bus.in_valid;
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.sub ? ~bus.cin : bus.cin;
      assign s_in = '0;
    end else begin : src
      assign v_in = stg[k-1].pipe.v_r;
      assign a_in = stg[k-1].pipe.a_r;
      assign b_in = stg[k-1].pipe.b_r;
      assign c_in = stg[k-1].pipe.c_r;
      assign s_in = stg[k-1].pipe.s_r;
    end

    // Lower operand bits are already consumed by earlier stages.
    assign unused_in = ^{a_in, b_in};

    always_comb begin
      c_mid = c_in;
      s_out = s_in;
      p0    = '0;
      p1    = '0;
      for (int j = 0; j < BPS; j++) begin
        p0 = {1'b0, a_in[(k*BPS+j)*B +: B]} + {1'b0, b_in[(k*BPS+j)*B +: B]};
        p1 = {1'b0, a_in[(k*BPS+j)*B +: B]} + {1'b0, b_in[(k*BPS+j)*B +: B]}
           + {{B{1'b0}}, 1'b1};
        s_out[(k*BPS+j)*B +: B] = c_mid ? p1[B-1:0] : p0[B-1:0];
        c_mid                   = c_mid ? p1[B] : p0[B];
      end
      c_out = c_mid;
    end

    if (k < S - 1) begin : pipe
      logic         v_r;
      logic         c_r;
      logic [N-1:0] a_r;
      logic [N-1:0] b_r;
      logic [N-1:0] s_r;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_r <= 1'b0;
          c_r <= 1'b0;
          a_r <= '0;
          b_r <= '0;
          s_r <= '0;
        end else if (advance) begin
          v_r <= v_in;
          c_r <= c_out;
          a_r <= a_in;
          b_r <= b_in;
          s_r <= s_out;
        end
      end
    end else begin : fin
      logic         ovf;
      logic [N-1:0] res;

      always_comb begin
        ovf = (a_in[N-1] == b_in[N-1]) && (s_out[N-1] != a_in[N-1]);
        res = s_out;
`ifdef CSEL_SATURATE_EN
        if (ovf) begin
          res = a_in[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          bus.out_valid <= 1'b0;
          bus.sum       <= '0;
          bus.cout      <= 1'b0;
          bus.overflow  <= 1'b0;
          bus.zero      <= 1'b0;
        end else if (advance) begin
          bus.out_valid <= v_in;
          bus.sum       <= res;
          bus.cout      <= c_out;
          bus.overflow  <= ovf;
          bus.zero      <= (res == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb/tb_pipelined_carry_select_adder.sv - self-checking bench for pipelined_carry_select_adder (defaults N=32,B=4,BPS=2)
module tb_pipelined_carry_select_adder;
  localparam int N = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_carry_select_adder_if #(.N(N)) bus ();

  pipelined_carry_select_adder #(.N(N), .B(4), .BPS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  int   n_vec = 0;
  int   n_err = 0;
  res_t q[$];
  logic held = 1'b0;
  res_t held_v;

  // Reference result from signed/unsigned integer arithmetic.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint sa, sb, ua, ub, sres;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (sub) begin
      sres   = sa - sb - longint'(cin);
      r.cout = (ua >= ub + longint'(cin));
    end else begin
      sres   = sa + sb + longint'(cin);
      r.cout = ((ua + ub + longint'(cin)) > 64'sd4294967295);
    end
    r.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    r.sum = sres[31:0];
`ifdef CSEL_SATURATE_EN
    if (r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held && bus.out_valid) begin
        check("stall_hold_sum", bus.sum, held_v.sum);
        check("stall_hold_flags", {bus.cout, bus.overflow, bus.zero},
              {held_v.cout, held_v.ovf, held_v.zero});
      end
      held   = bus.out_valid && !bus.out_ready;
      held_v = '{sum: bus.sum, cout: bus.cout, ovf: bus.overflow, zero: bus.zero};
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = q.pop_front();
          check("model_sum", bus.sum, e.sum);
          check("model_cout", bus.cout, e.cout);
          check("model_overflow", bus.overflow, e.ovf);
          check("model_zero", bus.zero, e.zero);
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    end
  end

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez);
    int lat;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    #1;
    check("send_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 4);
    check("lit_sum", bus.sum, es);
    check("lit_cout", bus.cout, ec);
    check("lit_overflow", bus.overflow, eo);
    check("lit_zero", bus.zero, ez);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input int stall_at, input int stall_len);
    int   sent = 0;
    int   cyc  = 0;
    logic acc, stall;
    logic pend = 1'b0;
    while (sent < n && cyc < 200) begin
      stall         = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      bus.out_ready = !stall;
      if (!pend) begin
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.cin = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
        pend    = 1'b1;
      end
      bus.in_valid = 1'b1;
      #1;
      if (stall) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
      end
      if (stall_len == 0 && cyc >= 4) check("stream_contig", bus.out_valid, 1);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    check("stream_sent", sent, n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && cyc < 300) begin
      #1;
      if (stall_len == 0) check("stream_contig", bus.out_valid, 1);
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    res_t r;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_flags", {bus.cout, bus.overflow, bus.zero}, 3'b000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    r = model(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("pin_model_add", r.sum, 32'h0000_0100);
    r = model(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    check("pin_model_ovf", {r.ovf, r.cout}, 2'b11);
    r = model(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);
    check("pin_model_borrow", {r.sum, r.cout}, {32'hFFFF_FFFD, 1'b0});

    send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`ifdef CSEL_SATURATE_EN
    send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    send_one(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
    send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    send_one(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
    send_one(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_one(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);

    stream(16, 0, 0);
    stream(8, 5, 5);

    for (int i = 0; i < 3; i++) begin
      bus.a = 32'h1111_0000 + i; bus.b = 32'h2; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("no_stale", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    send_one(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    check("final_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
